chacha_aead_host_driver: RTL and testbench



---
 rtl/chacha_aead_pkg.sv | 32 +++
 rtl/chacha_aead_host_driver_watchdog.sv | 32 +++
 rtl/chacha_aead_host_driver.sv | 212 +++++++++++++++++++++
 tb/tb_chacha_aead_host_driver.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_aead_pkg.sv
// Shared definitions for the ChaCha20-Poly1305 host driver.
// Holds the default widths, the default watchdog timeout and the driver
// state encoding, plus a helper that identifies the timed core-wait states.
package chacha_aead_pkg;

  localparam int unsigned AEAD_DATA_W  = 512;
  localparam int unsigned AEAD_KEY_W   = 256;
  localparam int unsigned AEAD_NONCE_W = 96;
  localparam int unsigned AEAD_TAG_W   = 128;
  localparam int unsigned AEAD_CNT_W   = 16;
  localparam int unsigned AEAD_TIMEOUT = 1024;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_RDY,
    ST_WAIT_IN,
    ST_NEXT,
    ST_WAIT_VAL,
    ST_OUT,
    ST_DONE,
    ST_WAIT_TAG,
    ST_TAG,
    ST_ERROR
  } aead_drv_state_t;

  // States in which the driver waits on the core and the watchdog runs.
  function automatic logic is_core_wait(aead_drv_state_t s);
    return (s == ST_WAIT_RDY) || (s == ST_WAIT_VAL) || (s == ST_WAIT_TAG);
  endfunction

endpackage

// File: rtl/chacha_aead_host_driver_watchdog.sv
// aead_watchdog: cycle counter guarding the core-wait states.
//   clk, rst : clock, synchronous active-high reset
//   clear    : forces the count to zero
//   enable   : counts one per cycle while high (saturates at TIMEOUT)
//   expired  : high while the count equals TIMEOUT
module aead_watchdog
  import chacha_aead_pkg::*;
#(
  parameter int unsigned TIMEOUT = AEAD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/chacha_aead_host_driver.sv
// chacha_aead_host_driver: host-side initiator for chacha20_poly1305_core.
// Accepts a session request (start + cfg_key/cfg_nonce/cfg_encdec), feeds
// upstream blocks (in_*) to the core one at a time using init/next/done
// pulses, presents each result on the out_* stream and finally the session
// tag on tag_*. busy/err/blk_count report status. core_* ports connect to
// the core. A watchdog moves the driver to a sticky error state if the core
// stalls in any wait state; only rst leaves that state. All outputs are
// registered.
module chacha_aead_host_driver
  import chacha_aead_pkg::*;
#(
  parameter int unsigned DATA_W  = AEAD_DATA_W,
  parameter int unsigned KEY_W   = AEAD_KEY_W,
  parameter int unsigned NONCE_W = AEAD_NONCE_W,
  parameter int unsigned TIMEOUT = AEAD_TIMEOUT,
  parameter int unsigned CNT_W   = AEAD_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEY_W-1:0]      cfg_key,
  input  logic [NONCE_W-1:0]    cfg_nonce,
  input  logic                  cfg_encdec,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  tag_valid,
  input  logic                  tag_ready,
  output logic [AEAD_TAG_W-1:0] tag_out,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      blk_count,
  output logic                  core_init,
  output logic                  core_next,
  output logic                  core_done,
  output logic                  core_encdec,
  output logic [KEY_W-1:0]      core_key,
  output logic [NONCE_W-1:0]    core_nonce,
  output logic [DATA_W-1:0]     core_data_in,
  input  logic                  core_ready,
  input  logic                  core_valid,
  input  logic                  core_tag_ok,
  input  logic [DATA_W-1:0]     core_data_out,
  input  logic [AEAD_TAG_W-1:0] core_tag
);

  aead_drv_state_t state;
  logic            settled;    // first cycle of a wait state has passed
  logic            last_flag;  // current block was flagged in_last
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expired;

  // Clearing whenever the FSM is outside a wait state zeroes the count on
  // every entry, since each wait state is only reached from a non-wait one.
  assign wd_enable = is_core_wait(state);
  assign wd_clear  = !is_core_wait(state);

  aead_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      settled      <= 1'b0;
      last_flag    <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      tag_valid    <= 1'b0;
      tag_out      <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      blk_count    <= '0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_done    <= 1'b0;
      core_encdec  <= 1'b0;
      core_key     <= '0;
      core_nonce   <= '0;
      core_data_in <= '0;
    end else begin
      // Pulses are raised on the transition into their state and dropped
      // here on the following cycle.
      core_init <= 1'b0;
      core_next <= 1'b0;
      core_done <= 1'b0;
      settled   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            core_key    <= cfg_key;
            core_nonce  <= cfg_nonce;
            core_encdec <= cfg_encdec;
            blk_count   <= '0;
            busy        <= 1'b1;
            core_init   <= 1'b1;
            state       <= ST_INIT;
          end
        end

        ST_INIT: begin
          state <= ST_WAIT_RDY;
        end

        ST_WAIT_RDY: begin
          settled <= 1'b1;
          if (settled && core_ready) begin
            in_ready <= 1'b1;
            state    <= ST_WAIT_IN;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end
        end

        ST_WAIT_IN: begin
          if (in_valid) begin
            in_ready     <= 1'b0;
            core_data_in <= in_data;
            last_flag    <= in_last;
            blk_count    <= blk_count + CNT_W'(1);
            core_next    <= 1'b1;
            state        <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          state <= ST_WAIT_VAL;
        end

        ST_WAIT_VAL: begin
          settled <= 1'b1;
          if (settled && core_valid) begin
            out_data  <= core_data_out;
            out_last  <= last_flag;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_flag) begin
              core_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT_RDY;
            end
          end
        end

        ST_DONE: begin
          state <= ST_WAIT_TAG;
        end

        ST_WAIT_TAG: begin
          settled <= 1'b1;
          if (settled && core_tag_ok) begin
            tag_out   <= core_tag;
            tag_valid <= 1'b1;
            state     <= ST_TAG;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end
        end

        ST_TAG: begin
          if (tag_ready) begin
            tag_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_ERROR: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          tag_valid <= 1'b0;
          busy      <= 1'b1;
          err       <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_aead_host_driver.sv
// Self-checking bench for chacha_aead_host_driver with a behavioural core
// model of configurable latency. Table-driven sessions plus directed
// sequences for reset-abort and watchdog timeout.
module tb_chacha_aead_host_driver;
  import chacha_aead_pkg::*;

  localparam int unsigned DW    = AEAD_DATA_W;
  localparam int unsigned KW    = AEAD_KEY_W;
  localparam int unsigned NW    = AEAD_NONCE_W;
  localparam int unsigned TW    = AEAD_TAG_W;
  localparam int unsigned CW    = AEAD_CNT_W;
  localparam int unsigned TMO   = 1024;
  localparam int unsigned BOUND = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [KW-1:0] cfg_key;
  logic [NW-1:0] cfg_nonce;
  logic          cfg_encdec;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          tag_valid;
  logic          tag_ready;
  logic [TW-1:0] tag_out;
  logic          busy;
  logic          err;
  logic [CW-1:0] blk_count;
  logic          core_init;
  logic          core_next;
  logic          core_done;
  logic          core_encdec;
  logic [KW-1:0] core_key;
  logic [NW-1:0] core_nonce;
  logic [DW-1:0] core_data_in;
  logic          core_ready;
  logic          core_valid;
  logic          core_tag_ok;
  logic [DW-1:0] core_data_out;
  logic [TW-1:0] core_tag;

  chacha_aead_host_driver #(
    .DATA_W  (DW),
    .KEY_W   (KW),
    .NONCE_W (NW),
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_key       (cfg_key),
    .cfg_nonce     (cfg_nonce),
    .cfg_encdec    (cfg_encdec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .tag_valid     (tag_valid),
    .tag_ready     (tag_ready),
    .tag_out       (tag_out),
    .busy          (busy),
    .err           (err),
    .blk_count     (blk_count),
    .core_init     (core_init),
    .core_next     (core_next),
    .core_done     (core_done),
    .core_encdec   (core_encdec),
    .core_key      (core_key),
    .core_nonce    (core_nonce),
    .core_data_in  (core_data_in),
    .core_ready    (core_ready),
    .core_valid    (core_valid),
    .core_tag_ok   (core_tag_ok),
    .core_data_out (core_data_out),
    .core_tag      (core_tag)
  );

  // Core model: ready/valid/tag_ok come up model_lat cycles after the
  // respective pulse is seen; result = data ^ replicated low key word,
  // tag = {nonce, number of next pulses since init}.
  int unsigned model_lat = 0;
  logic        never_valid = 1'b0;
  int unsigned rcnt, vcnt, tcnt, nblk;
  logic        rpend, vpend, tpend;

  always @(posedge clk) begin
    if (rst) begin
      core_ready    <= 1'b0;
      core_valid    <= 1'b0;
      core_tag_ok   <= 1'b0;
      core_data_out <= '0;
      core_tag      <= '0;
      rpend <= 1'b0; vpend <= 1'b0; tpend <= 1'b0;
      rcnt  <= 0;    vcnt  <= 0;    tcnt  <= 0;   nblk <= 0;
    end else if (core_init) begin
      core_ready  <= 1'b0;
      core_valid  <= 1'b0;
      core_tag_ok <= 1'b0;
      rpend <= 1'b1;
      rcnt  <= model_lat;
      nblk  <= 0;
    end else if (core_next) begin
      core_ready    <= 1'b0;
      core_valid    <= 1'b0;
      vpend         <= 1'b1;
      vcnt          <= model_lat;
      nblk          <= nblk + 1;
      core_data_out <= core_data_in ^ {16{core_key[31:0]}};
    end else if (core_done) begin
      tpend <= 1'b1;
      tcnt  <= model_lat;
    end else begin
      if (rpend) begin
        if (rcnt == 0) begin core_ready <= 1'b1; rpend <= 1'b0; end
        else rcnt <= rcnt - 1;
      end
      if (vpend && !never_valid) begin
        if (vcnt == 0) begin core_valid <= 1'b1; core_ready <= 1'b1; vpend <= 1'b0; end
        else vcnt <= vcnt - 1;
      end
      if (tpend) begin
        if (tcnt == 0) begin core_tag_ok <= 1'b1; core_tag <= {core_nonce, nblk}; tpend <= 1'b0; end
        else tcnt <= tcnt - 1;
      end
    end
  end

  // Pulse monitor: counts high cycles of each pulse and any overlap.
  int unsigned n_init = 0, n_next = 0, n_done = 0, n_overlap = 0;
  always @(posedge clk) begin
    n_init <= n_init + 32'(core_init);
    n_next <= n_next + 32'(core_next);
    n_done <= n_done + 32'(core_done);
    if (int'(core_init) + int'(core_next) + int'(core_done) > 1) n_overlap <= n_overlap + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctrl"}, DW'({in_ready, out_valid, out_last, tag_valid, busy, err,
                               core_init, core_next, core_done, core_encdec, blk_count}), '0);
    check({pfx, "_out_data"}, out_data, '0);
    check({pfx, "_tag"}, DW'(tag_out), '0);
    check({pfx, "_key"}, DW'(core_key), '0);
    check({pfx, "_nonce"}, DW'(core_nonce), '0);
    check({pfx, "_data_in"}, core_data_in, '0);
  endtask

  typedef struct {
    logic [KW-1:0] key;
    logic [NW-1:0] nonce;
    logic          enc;
    int unsigned   nblk;
    logic [63:0]   base;
    int unsigned   lat;
    logic          poke_start;
    logic          backpressure;
    int unsigned   exp_start_lat;
    int unsigned   exp_blk_lat;
  } vec_t;

  vec_t vecs[3];

  task automatic run_session(input vec_t v);
    int unsigned   i0, nx0, d0, ov0, cyc, nxb;
    logic [DW-1:0] blk, held;
    logic          stable, lastb;
    model_lat = v.lat;
    i0 = n_init; nx0 = n_next; d0 = n_done; ov0 = n_overlap;
    cfg_key = v.key; cfg_nonce = v.nonce; cfg_encdec = v.enc; start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", DW'(busy), DW'(1'b1));
    check("core_key", DW'(core_key), DW'(v.key));
    check("core_nonce", DW'(core_nonce), DW'(v.nonce));
    check("core_encdec", DW'(core_encdec), DW'(v.enc));
    cyc = 0;
    while (!in_ready && cyc < BOUND) begin tick; cyc++; end
    check("start_to_in_ready", DW'(cyc), DW'(v.exp_start_lat));

    for (int unsigned b = 0; b < v.nblk; b++) begin
      blk = {8{v.base + 64'(b)}};
      lastb = (b == v.nblk - 1);
      in_data = blk; in_last = lastb; in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < BOUND) begin tick; cyc++; end
      check("in_ready_seen", DW'(in_ready), DW'(1'b1));
      tick;
      in_valid = 1'b0;
      cyc = 0;
      if (v.poke_start && b == 0) begin
        cfg_key = ~v.key; cfg_nonce = ~v.nonce; cfg_encdec = ~v.enc; start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
      end
      while (!out_valid && cyc < BOUND) begin tick; cyc++; end
      check("blk_latency", DW'(cyc), DW'(v.exp_blk_lat));
      check("out_data", out_data, blk ^ {16{v.key[31:0]}});
      check("out_last", DW'(out_last), DW'(lastb));
      if (v.backpressure && b == 0) begin
        held = out_data; stable = 1'b1; nxb = n_next;
        repeat (50) begin
          tick;
          if (!out_valid || out_data !== held || err) stable = 1'b0;
        end
        check("bp_stable", DW'(stable), DW'(1'b1));
        check("bp_no_next", DW'(n_next - nxb), '0);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check("out_valid_drop", DW'(out_valid), '0);
    end

    cyc = 0;
    while (!tag_valid && cyc < BOUND) begin tick; cyc++; end
    check("tag_valid_seen", DW'(tag_valid), DW'(1'b1));
    check("tag", DW'(tag_out), DW'({v.nonce, 32'(v.nblk)}));
    check("blk_count", DW'(blk_count), DW'(v.nblk));
    check("key_held", DW'({core_key, core_nonce, core_encdec}), DW'({v.key, v.nonce, v.enc}));
    tag_ready = 1'b1;
    tick;
    tag_ready = 1'b0;
    check("idle_after_tag", DW'({busy, tag_valid, err}), '0);
    check("pulse_init", DW'(n_init - i0), DW'(1));
    check("pulse_next", DW'(n_next - nx0), DW'(v.nblk));
    check("pulse_done", DW'(n_done - d0), DW'(1));
    check("pulse_overlap", DW'(n_overlap - ov0), '0);
  endtask

  initial begin
    int unsigned cyc;
    rst = 1'b1; start = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_encdec = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; tag_ready = 1'b0;

    vecs[0] = '{key: {4{64'h0123456789abcdef}}, nonce: {32'h11111111, 32'h22222222, 32'h33333333},
                enc: 1'b1, nblk: 1, base: 64'h0000000100000002, lat: 0,
                poke_start: 1'b0, backpressure: 1'b0, exp_start_lat: 3, exp_blk_lat: 3};
    vecs[1] = '{key: {8{32'hdeadc0de}}, nonce: 96'h0a0b0c0d_0e0f1011_12131415,
                enc: 1'b0, nblk: 10, base: 64'hcafebabedeadbeef, lat: 20,
                poke_start: 1'b0, backpressure: 1'b0, exp_start_lat: 23, exp_blk_lat: 23};
    vecs[2] = '{key: {8{32'h5a5aa5a5}}, nonce: 96'hffff0000_1234abcd_00000007,
                enc: 1'b1, nblk: 3, base: 64'h0011223344556677, lat: 2,
                poke_start: 1'b1, backpressure: 1'b1, exp_start_lat: 5, exp_blk_lat: 5};

    repeat (3) tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 3; i++) run_session(vecs[i]);

    // Reset while waiting for core_valid, then a clean session.
    model_lat = 20;
    cfg_key = {8{32'h13572468}}; cfg_nonce = 96'h1; cfg_encdec = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < BOUND) begin tick; cyc++; end
    in_data = {16{32'h0badf00d}}; in_last = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    check("midrst_busy_before", DW'(busy), DW'(1'b1));
    rst = 1'b1;
    tick;
    check_all_zero("midrst");
    rst = 1'b0;
    tick;
    run_session(vecs[0]);

    // Core never returns core_valid: watchdog expiry and sticky error.
    never_valid = 1'b1;
    model_lat = 0;
    cfg_key = vecs[0].key; cfg_nonce = vecs[0].nonce; cfg_encdec = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < BOUND) begin tick; cyc++; end
    in_data = {16{32'h600df00d}}; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("to_next_pulse", DW'(core_next), DW'(1'b1));
    cyc = 0;
    while (!err && cyc < BOUND) begin tick; cyc++; end
    check("timeout_cycles", DW'(cyc), DW'(TMO + 2));
    repeat (20) tick;
    check("err_sticky", DW'({err, busy}), DW'(2'b11));
    check("err_handshakes_low", DW'({in_ready, out_valid, tag_valid, core_init, core_next, core_done}), '0);
    rst = 1'b1;
    tick;
    check("err_cleared_by_rst", DW'({err, busy}), '0);
    rst = 1'b0;
    never_valid = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
